// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: control-word layout,
// forwarding-select encodings and the destination-select helper.
package ctrl_pkg;

  localparam int CTRL_W     = 8;
  localparam int REG_ADDR_W = 5;

  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_ALU_OP_HI = 6;
  localparam int CTRL_ALU_OP_LO = 4;
  localparam int CTRL_MEM_WRITE = 3;
  localparam int CTRL_REG_DST   = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_MEM_READ  = 0;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // R-type writes rd, loads and immediates write rt.
  function automatic logic [REG_ADDR_W-1:0] dest_sel(
    input logic [CTRL_W-1:0]     ctrl,
    input logic [REG_ADDR_W-1:0] rt,
    input logic [REG_ADDR_W-1:0] rd
  );
    return ctrl[CTRL_REG_DST] ? rd : rt;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decode-to-pipeline control interface: the decoder drives the instruction
// fields, the pipeline answers with the load-use stall request.
interface ctrl_pipeline_if;
  import ctrl_pkg::*;

  logic                  id_valid;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  stall_if_id;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd,
    input  stall_if_id
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd,
    output stall_if_id
  );

endinterface

// File: rtl/ctrl_pipeline_fwd_hazard_unit.sv
// Combinational load-use stall detection and EX-stage operand forwarding
// selects. Register 0 never participates in either.
module fwd_hazard_unit
  import ctrl_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  stall_if_id,
  output fwd_sel_e              fwd_a,
  output fwd_sel_e              fwd_b
);

  // The younger producer (EX/MEM) wins when both later stages match.
  function automatic fwd_sel_e fwd_select(input logic [REG_ADDR_W-1:0] src);
    if (mem_reg_write && (mem_dest != '0) && (mem_dest == src))
      return FWD_EXMEM;
    else if (wb_reg_write && (wb_dest != '0) && (wb_dest == src))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  always_comb begin
    stall_if_id = 1'b0;
    fwd_a       = FWD_REG;
    fwd_b       = FWD_REG;

    stall_if_id = ex_mem_read && (ex_dest != '0) && id_valid &&
                  ((ex_dest == id_rs) || (ex_dest == id_rt));
    fwd_a       = fwd_select(ex_rs);
    fwd_b       = fwd_select(ex_rt);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers. Only ID/EX can take a bubble;
// the later stages always advance.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ctrl_pipeline_if.slave        dec,
  input  logic                  flush,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  ex_alu_src,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CTRL_W-1:0]     mem_ctrl,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dest
);

  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  stall;
  logic                  insert_bubble;
  fwd_sel_e              fwd_a_sel;
  fwd_sel_e              fwd_b_sel;

  assign insert_bubble = !dec.id_valid || flush || stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl       <= CTRL_BUBBLE;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_dest       <= '0;
      mem_ctrl      <= CTRL_BUBBLE;
      mem_dest      <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_dest       <= '0;
    end else begin
      mem_ctrl      <= ex_ctrl;
      mem_dest      <= ex_dest;
      wb_reg_write  <= mem_ctrl[CTRL_REG_WRITE];
      wb_mem_to_reg <= mem_ctrl[CTRL_MEM_READ];
      wb_dest       <= mem_dest;
      if (insert_bubble) begin
        ex_ctrl <= CTRL_BUBBLE;
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_dest <= '0;
      end else begin
        ex_ctrl <= dec.id_ctrl;
        ex_rs   <= dec.id_rs;
        ex_rt   <= dec.id_rt;
        ex_dest <= dest_sel(dec.id_ctrl, dec.id_rt, dec.id_rd);
      end
    end
  end

  assign ex_alu_src      = ex_ctrl[CTRL_MEM_READ] | ex_ctrl[CTRL_MEM_WRITE];
  assign dec.stall_if_id = stall;
  assign fwd_a           = fwd_a_sel;
  assign fwd_b           = fwd_b_sel;

  fwd_hazard_unit u_fwd_hazard (
    .id_valid      (dec.id_valid),
    .id_rs         (dec.id_rs),
    .id_rt         (dec.id_rt),
    .ex_mem_read   (ex_ctrl[CTRL_MEM_READ]),
    .ex_dest       (ex_dest),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_reg_write (mem_ctrl[CTRL_REG_WRITE]),
    .mem_dest      (mem_dest),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .stall_if_id   (stall),
    .fwd_a         (fwd_a_sel),
    .fwd_b         (fwd_b_sel)
  );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: expectations for each cycle are queued
// while stimulus is driven and popped when the outputs are sampled.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  localparam logic [7:0] ADD = 8'b1_010_0_1_00;
  localparam logic [7:0] SUB = 8'b1_011_0_1_00;
  localparam logic [7:0] LW  = 8'b1_001_0_0_01;
  localparam logic [7:0] SW  = 8'b0_001_1_0_00;
  localparam logic [7:0] BEQ = 8'b0_110_0_0_10;

  typedef enum int {
    F_STALL, F_EXCTRL, F_EXRS, F_EXRT, F_ALUSRC, F_FWDA, F_FWDB,
    F_MEMCTRL, F_MEMDEST, F_WBRW, F_WBM2R, F_WBDEST
  } field_e;

  typedef struct {
    string      tag;
    field_e     fld;
    logic [7:0] val;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [CTRL_W-1:0]     ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_alu_src;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CTRL_W-1:0]     mem_ctrl;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [REG_ADDR_W-1:0] wb_dest;

  ctrl_pipeline_if dec_if ();

  ctrl_pipeline dut (
    .clk           (clk),
    .rst           (rst),
    .dec           (dec_if.slave),
    .flush         (flush),
    .ex_ctrl       (ex_ctrl),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_alu_src    (ex_alu_src),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .mem_ctrl      (mem_ctrl),
    .mem_dest      (mem_dest),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dest       (wb_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t scoreboard[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] observe(input field_e f);
    case (f)
      F_STALL:   return {7'd0, dec_if.stall_if_id};
      F_EXCTRL:  return ex_ctrl;
      F_EXRS:    return {3'd0, ex_rs};
      F_EXRT:    return {3'd0, ex_rt};
      F_ALUSRC:  return {7'd0, ex_alu_src};
      F_FWDA:    return {6'd0, fwd_a};
      F_FWDB:    return {6'd0, fwd_b};
      F_MEMCTRL: return mem_ctrl;
      F_MEMDEST: return {3'd0, mem_dest};
      F_WBRW:    return {7'd0, wb_reg_write};
      F_WBM2R:   return {7'd0, wb_mem_to_reg};
      default:   return {3'd0, wb_dest};
    endcase
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] c,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic fl);
    dec_if.id_valid = v;
    dec_if.id_ctrl  = c;
    dec_if.id_rs    = rs;
    dec_if.id_rt    = rt;
    dec_if.id_rd    = rd;
    flush           = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic expect_val(input string tag, input field_e f, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.fld = f;
    e.val = v;
    scoreboard.push_back(e);
  endtask

  // Samples mid-cycle, well clear of the rising edge.
  task automatic checkOutput();
    exp_t e;
    logic [7:0] obs;
    #2;
    while (scoreboard.size() > 0) begin
      e   = scoreboard.pop_front();
      obs = observe(e.fld);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    // reset state
    idle();
    expect_val("rst_stall", F_STALL, 8'h00);
    expect_val("rst_exctrl", F_EXCTRL, 8'h00);
    expect_val("rst_fwda", F_FWDA, 8'h00);
    expect_val("rst_fwdb", F_FWDB, 8'h00);
    expect_val("rst_memctrl", F_MEMCTRL, 8'h00);
    expect_val("rst_wbrw", F_WBRW, 8'h00);
    expect_val("rst_wbdest", F_WBDEST, 8'h00);
    checkOutput(); tick();

    // test 1: fill with R-type rd=3, then reset mid-flight
    applyStimulus(1'b1, ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    expect_val("t1_stall0", F_STALL, 8'h00);
    checkOutput(); tick();
    expect_val("t1_exctrl", F_EXCTRL, ADD);
    expect_val("t1_exrs", F_EXRS, 8'd1);
    expect_val("t1_exrt", F_EXRT, 8'd2);
    expect_val("t1_alusrc", F_ALUSRC, 8'h00);
    checkOutput(); tick();
    expect_val("t1_memctrl", F_MEMCTRL, ADD);
    expect_val("t1_memdest", F_MEMDEST, 8'd3);
    checkOutput(); tick();
    rst = 1'b1;
    expect_val("t1_wbrw", F_WBRW, 8'h01);
    expect_val("t1_wbdest", F_WBDEST, 8'd3);
    expect_val("t1_wbm2r", F_WBM2R, 8'h00);
    checkOutput(); tick();
    rst = 1'b0;
    idle();
    expect_val("t1_post_exctrl", F_EXCTRL, 8'h00);
    expect_val("t1_post_memctrl", F_MEMCTRL, 8'h00);
    expect_val("t1_post_memdest", F_MEMDEST, 8'h00);
    expect_val("t1_post_wbrw", F_WBRW, 8'h00);
    expect_val("t1_post_wbdest", F_WBDEST, 8'h00);
    expect_val("t1_post_stall", F_STALL, 8'h00);
    checkOutput(); tick();

    // test 2: single lw rt=5, latency EX/MEM/WB
    applyStimulus(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
    expect_val("t2_c0_wbrw", F_WBRW, 8'h00);
    checkOutput(); tick();
    idle();
    expect_val("t2_c1_exctrl", F_EXCTRL, LW);
    expect_val("t2_c1_alusrc", F_ALUSRC, 8'h01);
    expect_val("t2_c1_memctrl", F_MEMCTRL, 8'h00);
    checkOutput(); tick();
    expect_val("t2_c2_memctrl", F_MEMCTRL, LW);
    expect_val("t2_c2_memdest", F_MEMDEST, 8'd5);
    expect_val("t2_c2_wbrw", F_WBRW, 8'h00);
    checkOutput(); tick();
    expect_val("t2_c3_wbrw", F_WBRW, 8'h01);
    expect_val("t2_c3_wbm2r", F_WBM2R, 8'h01);
    expect_val("t2_c3_wbdest", F_WBDEST, 8'd5);
    checkOutput(); tick();
    expect_val("t2_c4_wbrw", F_WBRW, 8'h00);
    expect_val("t2_c4_wbdest", F_WBDEST, 8'h00);
    checkOutput(); tick();

    // test 3: load-use
    applyStimulus(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
    checkOutput(); tick();
    applyStimulus(1'b1, ADD, 5'd5, 5'd6, 5'd7, 1'b0);
    expect_val("t3_stall1", F_STALL, 8'h01);
    checkOutput(); tick();
    expect_val("t3_bubble", F_EXCTRL, 8'h00);
    expect_val("t3_stall_once", F_STALL, 8'h00);
    checkOutput(); tick();
    idle();
    expect_val("t3_add_ex", F_EXCTRL, ADD);
    expect_val("t3_add_rs", F_EXRS, 8'd5);
    expect_val("t3_fwda", F_FWDA, 8'h01);
    expect_val("t3_fwdb", F_FWDB, 8'h00);
    checkOutput(); tick();
    expect_val("t3_nodup", F_EXCTRL, 8'h00);
    checkOutput(); tick();

    // test 4: forwarding priority, then rd=0
    applyStimulus(1'b1, ADD, 5'd1, 5'd2, 5'd4, 1'b0);
    checkOutput(); tick();
    checkOutput(); tick();
    applyStimulus(1'b1, SUB, 5'd4, 5'd4, 5'd8, 1'b0);
    expect_val("t4_nostall", F_STALL, 8'h00);
    checkOutput(); tick();
    idle();
    expect_val("t4_sub_ex", F_EXCTRL, SUB);
    expect_val("t4_fwda", F_FWDA, 8'h02);
    expect_val("t4_fwdb", F_FWDB, 8'h02);
    checkOutput(); tick();
    applyStimulus(1'b1, ADD, 5'd1, 5'd2, 5'd0, 1'b0);
    checkOutput(); tick();
    checkOutput(); tick();
    applyStimulus(1'b1, SUB, 5'd0, 5'd0, 5'd8, 1'b0);
    checkOutput(); tick();
    idle();
    expect_val("t4_r0_exctrl", F_EXCTRL, SUB);
    expect_val("t4_r0_fwda", F_FWDA, 8'h00);
    expect_val("t4_r0_fwdb", F_FWDB, 8'h00);
    checkOutput(); tick();

    // test 5: flush kills the sw in ID
    applyStimulus(1'b1, BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    checkOutput(); tick();
    applyStimulus(1'b1, SW, 5'd1, 5'd9, 5'd0, 1'b1);
    expect_val("t5_beq_ex", F_EXCTRL, BEQ);
    checkOutput(); tick();
    idle();
    expect_val("t5_flushed", F_EXCTRL, 8'h00);
    expect_val("t5_beq_mem", F_MEMCTRL, BEQ);
    checkOutput(); tick();
    expect_val("t5_no_sw_mem", F_MEMCTRL, 8'h00);
    checkOutput(); tick();

    // test 6: stall and flush together
    applyStimulus(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
    checkOutput(); tick();
    applyStimulus(1'b1, ADD, 5'd2, 5'd3, 5'd10, 1'b1);
    expect_val("t6_stall", F_STALL, 8'h01);
    expect_val("t6_lw_ex", F_EXCTRL, LW);
    checkOutput(); tick();
    idle();
    expect_val("t6_bubble", F_EXCTRL, 8'h00);
    expect_val("t6_stall_clr", F_STALL, 8'h00);
    checkOutput(); tick();
    expect_val("t6_nodup", F_EXCTRL, 8'h00);
    expect_val("t6_nodup_mem", F_MEMCTRL, 8'h00);
    checkOutput(); tick();

    // WB-only forward on operand b
    applyStimulus(1'b1, ADD, 5'd1, 5'd2, 5'd11, 1'b0);
    checkOutput(); tick();
    idle();
    checkOutput(); tick();
    applyStimulus(1'b1, SUB, 5'd3, 5'd11, 5'd12, 1'b0);
    checkOutput(); tick();
    idle();
    expect_val("wbfwd_exrt", F_EXRT, 8'd11);
    expect_val("wbfwd_fwdb", F_FWDB, 8'h01);
    expect_val("wbfwd_fwda", F_FWDA, 8'h00);
    checkOutput(); tick();

    // stall through rt, gated by id_valid
    applyStimulus(1'b1, LW, 5'd1, 5'd13, 5'd0, 1'b0);
    checkOutput(); tick();
    applyStimulus(1'b0, ADD, 5'd13, 5'd13, 5'd14, 1'b0);
    expect_val("stall_invalid", F_STALL, 8'h00);
    checkOutput();
    applyStimulus(1'b1, ADD, 5'd4, 5'd13, 5'd14, 1'b0);
    expect_val("stall_rt", F_STALL, 8'h01);
    checkOutput(); tick();
    idle();
    expect_val("stall_rt_bubble", F_EXCTRL, 8'h00);
    checkOutput(); tick();

    // store drives ALU source select
    applyStimulus(1'b1, SW, 5'd1, 5'd9, 5'd0, 1'b0);
    checkOutput(); tick();
    idle();
    expect_val("sw_exctrl", F_EXCTRL, SW);
    expect_val("sw_alusrc", F_ALUSRC, 8'h01);
    checkOutput(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
